secuenciador_fir: RTL and testbench
===================================

// Module: secuenciador_fir
// PURPOSE
//  Initiator side of the unidad_aritmetica interface (a, b, func -> y_sal, overflow_o).
//  Accepts one audio sample per handshake, shifts it into a TAPS-deep delay line and
//  computes one FIR output per sample by issuing alternating multiply/add operations
//  to an external unidad_aritmetica. One equalizer band filter per instance.
// PARAMETERS
//  LARGO   24  MSB index; all data words are LARGO+1 bits signed, Q8.16 (16 frac bits)
//  TAPS    8   filter length, >=2; CW = $clog2(TAPS)
// PORTS
//  clk            in   1        system clock, rising edge
//  rst_n          in   1        asynchronous reset, active low
//  muestra_in     in   LARGO+1  input sample, signed Q8.16
//  muestra_valid  in   1        producer has a sample
//  muestra_ready  out  1        block can accept a sample (IDLE only)
//  coef_addr      out  CW       coefficient index k
//  coef_in        in   LARGO+1  coefficient h[k], combinational from external ROM
//  au_a, au_b     out  LARGO+1  operands to unidad_aritmetica
//  au_func        out  2        1=suma, 2=multiplicacion, 0=idle
//  au_y           in   LARGO+1  result (y_sal), already saturated
//  au_ovf         in   1        overflow_o of current operation
//  y_out          out  LARGO+1  filtered sample, held until next result
//  y_valid        out  1        one-cycle pulse, y_out updated
//  ovf_flag       out  1        any saturation during last result, valid with y_valid
//  ovf_cnt        out  16       saturation event counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0 except muestra_ready=1; delay line x[0..TAPS-1], acc, prod, k=0; state IDLE.
//  FSM IDLE -> MUL -> SUM -> (MUL | DONE) -> IDLE.
//  IDLE: ready=1, au_func=0. On valid&&ready: x[i]<=x[i-1], x[0]<=muestra_in, acc<=0,
//   k<=0, ovf<=0 -> MUL. Valid without transfer: no state change.
//  MUL: au_func=2, coef_addr=k, au_a=x[k], au_b=coef_in; prod<=au_y; ovf|=au_ovf -> SUM.
//  SUM: au_func=1, au_a=acc, au_b=prod; acc<=au_y; ovf|=au_ovf;
//   k==TAPS-1 -> DONE, else k<=k+1 -> MUL.
//  DONE: y_out<=acc, ovf_flag<=ovf, y_valid=1 this cycle only, ready=0 -> IDLE.
//  Latency: accept edge to y_valid high = 2*TAPS+1 cycles; throughput 1 sample / 2*TAPS+2 cycles.
//  Arithmetic: no local add/mul; saturation is delegated entirely to unidad_aritmetica;
//   operands/results passed bit-exact, no truncation in this block.
//  Operand ports are registered from state/regs so au_y is sampled same cycle (unit is combinational).
//  Backpressure: valid held during busy is ignored (ready=0); sample neither lost nor duplicated.
//  k wrap: k never exceeds TAPS-1; returns to 0 only on next accept.
//  Reset mid-operation: immediate abort, delay line cleared, y_valid never issued for aborted sample.
// CONFIGURATION
//  SECUENCIADOR_OVF_CNT_EN defined: ovf_cnt increments by 1 in every MUL/SUM cycle with
//   au_ovf=1, saturates at 16'hFFFF, cleared only by reset.
//  Not defined: counter logic absent, ovf_cnt tied to 16'h0000.
// TESTING (TAPS=4, real unidad_aritmetica; h={0x10000,0x08000,0x04000,0x1FF8000})
//  Reset: rst_n=0 mid-run -> y_out=0, y_valid=0, au_func=0, ready=1 immediately.
//  Impulse: 0x10000 then 3x 0 -> y_out 0x10000,0x08000,0x04000,0x1FF8000; y_valid 9 cycles after accept.
//  Saturation: h all 0x10000, 4x 0x0FFFFFF -> y_out=0x0FFFFFF, ovf_flag=1; negative 0x1000000 -> 0x1000000.
//  Backpressure: valid held continuously, 3 samples -> ready high only in IDLE, 3 y_valid pulses, 10-cycle period.
//  Abort: reset in SUM of k=2, then impulse -> clean impulse response, no stale taps.
//  Macro on, saturation case -> ovf_cnt equals count of au_ovf cycles; macro off -> ovf_cnt=0.

Source files
------------

// File: rtl/secuenciador_fir.sv
// FIR sequencer: shifts one sample per handshake into a TAPS-deep delay line and drives
// an external combinational unidad_aritmetica with alternating multiply/add operations.
// Optional SECUENCIADOR_OVF_CNT_EN adds a saturating counter of overflow events.
module secuenciador_fir #(
    parameter  int LARGO = 24,
    parameter  int TAPS  = 8,
    localparam int CW    = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LARGO:0]   muestra_in,
    input  logic             muestra_valid,
    output logic             muestra_ready,
    output logic [CW-1:0]    coef_addr,
    input  logic [LARGO:0]   coef_in,
    output logic [LARGO:0]   au_a,
    output logic [LARGO:0]   au_b,
    output logic [1:0]       au_func,
    input  logic [LARGO:0]   au_y,
    input  logic             au_ovf,
    output logic [LARGO:0]   y_out,
    output logic             y_valid,
    output logic             ovf_flag,
    output logic [15:0]      ovf_cnt
);

    typedef enum logic [1:0] {IDLE, MUL, SUM, DONE} state_t;

    localparam logic [1:0] FUNC_IDLE = 2'd0;
    localparam logic [1:0] FUNC_SUMA = 2'd1;
    localparam logic [1:0] FUNC_MULT = 2'd2;

    state_t           state_q, state_d;
    logic [LARGO:0]   x_q [TAPS];
    logic [LARGO:0]   acc_q;
    logic [LARGO:0]   prod_q;
    logic [CW-1:0]    k_q;
    logic             ovf_q;
    logic             last_tap;
    logic             accept;

    assign last_tap  = (k_q == CW'(TAPS - 1));
    assign accept    = (state_q == IDLE) && muestra_valid;
    assign coef_addr = k_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        muestra_ready = 1'b0;
        au_func       = FUNC_IDLE;
        au_a          = '0;
        au_b          = '0;
        case (state_q)
            IDLE: begin
                muestra_ready = 1'b1;
                if (muestra_valid) state_d = MUL;
            end
            MUL: begin
                au_func = FUNC_MULT;
                au_a    = x_q[k_q];
                au_b    = coef_in;
                state_d = SUM;
            end
            SUM: begin
                au_func = FUNC_SUMA;
                au_a    = acc_q;
                au_b    = prod_q;
                state_d = last_tap ? DONE : MUL;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the delay line is an array but is still reset, so an aborted sample can
    // never leave stale taps behind for the next filter run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            k_q      <= '0;
            ovf_q    <= 1'b0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
                        x_q[0] <= muestra_in;
                        acc_q  <= '0;
                        k_q    <= '0;
                        ovf_q  <= 1'b0;
                    end
                end
                MUL: begin
                    prod_q <= au_y;
                    ovf_q  <= ovf_q | au_ovf;
                end
                SUM: begin
                    acc_q <= au_y;
                    ovf_q <= ovf_q | au_ovf;
                    if (!last_tap) k_q <= k_q + CW'(1);
                end
                DONE: begin
                    y_out    <= acc_q;
                    ovf_flag <= ovf_q;
                    y_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SECUENCIADOR_OVF_CNT_EN
    logic [15:0] cnt_q;

    // Counts every saturating operation, sticking at full scale instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_q == MUL || state_q == SUM) && au_ovf && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = cnt_q;
`else
    assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_secuenciador_fir.sv
// Self-checking bench for secuenciador_fir (TAPS=4) with a behavioural Q8.16 saturating
// arithmetic unit and a direct-form FIR reference model.
module tb_secuenciador_fir;

    localparam int LARGO = 24;
    localparam int TAPS  = 4;
    localparam int CW    = 2;
    localparam longint MAXV = 64'sd16777215;
    localparam longint MINV = -64'sd16777216;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LARGO:0]   muestra_in;
    logic             muestra_valid;
    logic             muestra_ready;
    logic [CW-1:0]    coef_addr;
    logic [LARGO:0]   coef_in;
    logic [LARGO:0]   au_a, au_b, au_y;
    logic [1:0]       au_func;
    logic             au_ovf;
    logic [LARGO:0]   y_out;
    logic             y_valid;
    logic             ovf_flag;
    logic [15:0]      ovf_cnt;

    logic [LARGO:0]   coef_rom [TAPS];

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int ready_cnt = 0;
    int pulse_cnt = 0;
    int last_pulse = -1;
    bit check_period = 1'b0;
    int unsigned model_cnt = 0;

    logic [LARGO:0] hist [TAPS];
    logic [LARGO:0] exp_y   [$];
    bit             exp_ovf [$];
    int             exp_edge[$];

    always #5 clk = ~clk;

    secuenciador_fir #(.LARGO(LARGO), .TAPS(TAPS)) dut (
        .clk(clk), .rst_n(rst_n),
        .muestra_in(muestra_in), .muestra_valid(muestra_valid), .muestra_ready(muestra_ready),
        .coef_addr(coef_addr), .coef_in(coef_in),
        .au_a(au_a), .au_b(au_b), .au_func(au_func), .au_y(au_y), .au_ovf(au_ovf),
        .y_out(y_out), .y_valid(y_valid), .ovf_flag(ovf_flag), .ovf_cnt(ovf_cnt)
    );

    assign coef_in = coef_rom[coef_addr];

    function automatic logic [LARGO+1:0] sat25(input longint v);
        if (v > MAXV) return {1'b1, 25'h0FFFFFF};
        if (v < MINV) return {1'b1, 25'h1000000};
        return {1'b0, v[LARGO:0]};
    endfunction

    function automatic logic [LARGO+1:0] q_mul(input logic signed [LARGO:0] a, input logic signed [LARGO:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat25(p >>> 16);
    endfunction

    function automatic logic [LARGO+1:0] q_add(input logic signed [LARGO:0] a, input logic signed [LARGO:0] b);
        return sat25(longint'(a) + longint'(b));
    endfunction

    // Behavioural unidad_aritmetica: combinational, saturating Q8.16.
    always_comb begin
        logic [LARGO+1:0] r;
        r = '0;
        case (au_func)
            2'd1:    r = q_add(au_a, au_b);
            2'd2:    r = q_mul(au_a, au_b);
            default: r = '0;
        endcase
        au_y   = r[LARGO:0];
        au_ovf = r[LARGO+1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef SECUENCIADOR_OVF_CNT_EN
        logic [31:0] c;
        c = model_cnt;
        return c[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    // Reference FIR: y = sum over k of h[k]*x[n-k], each op saturated in order.
    task automatic model_accept(input logic [LARGO:0] s);
        logic [LARGO+1:0] r;
        logic [LARGO:0]   acc, p;
        bit               o;
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        acc = '0;
        o   = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            r = q_mul(hist[k], coef_rom[k]);
            p = r[LARGO:0];
            o |= r[LARGO+1];
            if (r[LARGO+1] && model_cnt < 65535) model_cnt++;
            r = q_add(acc, p);
            acc = r[LARGO:0];
            o |= r[LARGO+1];
            if (r[LARGO+1] && model_cnt < 65535) model_cnt++;
        end
        exp_y.push_back(acc);
        exp_ovf.push_back(o);
        exp_edge.push_back(edge_cnt + 1);
    endtask

    task automatic monitor();
        if (y_valid) begin
            pulse_cnt++;
            if (exp_y.size() == 0) begin
                check("unexpected_y_valid", 32'(y_valid), 32'd0);
            end else begin
                check("y_out", 32'(y_out), 32'(exp_y.pop_front()));
                check("ovf_flag", 32'(ovf_flag), 32'(exp_ovf.pop_front()));
                check("latency", edge_cnt - exp_edge.pop_front(), 2 * TAPS + 1);
                check("ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt()));
            end
            if (check_period && last_pulse >= 0)
                check("pulse_period", edge_cnt - last_pulse, 2 * TAPS + 2);
            last_pulse = edge_cnt;
        end
    endtask

    // Called at a negedge; inputs are stable, so valid&&ready predicts the next edge's accept.
    task automatic cycle();
        if (muestra_valid && muestra_ready) begin
            model_accept(muestra_in);
            ready_cnt++;
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        muestra_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_y_out", 32'(y_out), 32'd0);
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_au_func", 32'(au_func), 32'd0);
        check("rst_ready", 32'(muestra_ready), 32'd1);
        check("rst_ovf_flag", 32'(ovf_flag), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        exp_y.delete();
        exp_ovf.delete();
        exp_edge.delete();
        for (int i = 0; i < TAPS; i++) hist[i] = '0;
        model_cnt = 0;
        last_pulse = -1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [LARGO:0] s);
        int guard;
        guard = 0;
        muestra_in = s;
        muestra_valid = 1'b1;
        while (!muestra_ready && guard < 40) begin
            cycle();
            guard++;
        end
        check("send_timeout", 32'(guard < 40), 32'd1);
        cycle();
        muestra_valid = 1'b0;
    endtask

    task automatic drain();
        muestra_valid = 1'b0;
        for (int i = 0; i < 40 && exp_y.size() > 0; i++) cycle();
        check("drain_pending", exp_y.size(), 0);
    endtask

    task automatic set_impulse_coefs();
        coef_rom[0] = 25'h0010000;
        coef_rom[1] = 25'h0008000;
        coef_rom[2] = 25'h0004000;
        coef_rom[3] = 25'h1FF8000;
    endtask

    function automatic logic [LARGO:0] rand_sample();
        int unsigned u;
        int t;
        u = $urandom();
        if (u[0]) return u[LARGO+1:1];
        t = int'($urandom_range(0, 131071)) - 65536;
        return t[LARGO:0];
    endfunction

    initial begin
        rst_n = 1'b0;
        muestra_valid = 1'b0;
        muestra_in = '0;
        set_impulse_coefs();
        @(negedge clk);
        do_reset();

        // Impulse with step-by-step operation sequence for the first sample.
        muestra_in = 25'h0010000;
        muestra_valid = 1'b1;
        cycle();
        muestra_valid = 1'b0;
        for (int j = 0; j < 2 * TAPS + 1; j++) begin
            if (j == 2 * TAPS) begin
                check("done_func", 32'(au_func), 32'd0);
            end else if (j % 2 == 0) begin
                check("mul_func", 32'(au_func), 32'd2);
                check("mul_addr", 32'(coef_addr), 32'(j / 2));
                check("mul_b", 32'(au_b), 32'(coef_rom[j / 2]));
            end else begin
                check("sum_func", 32'(au_func), 32'd1);
            end
            check("busy_ready", 32'(muestra_ready), 32'd0);
            cycle();
        end
        for (int i = 0; i < 3; i++) send('0);
        drain();

        // Positive then negative saturation with unity taps.
        do_reset();
        for (int k = 0; k < TAPS; k++) coef_rom[k] = 25'h0010000;
        for (int i = 0; i < 4; i++) send(25'h0FFFFFF);
        drain();
        for (int i = 0; i < 4; i++) send(25'h1000000);
        drain();

        // Random coefficients and samples with random gaps.
        do_reset();
        for (int k = 0; k < TAPS; k++) begin
            int t;
            t = int'($urandom_range(0, 262143)) - 131072;
            coef_rom[k] = t[LARGO:0];
        end
        for (int i = 0; i < 24; i++) begin
            send(rand_sample());
            repeat ($urandom_range(0, 3)) cycle();
        end
        drain();

        // Backpressure: valid held for three sample periods.
        do_reset();
        ready_cnt = 0;
        pulse_cnt = 0;
        check_period = 1'b1;
        muestra_valid = 1'b1;
        for (int i = 0; i < 3 * (2 * TAPS + 2); i++) begin
            muestra_in = rand_sample();
            cycle();
        end
        muestra_valid = 1'b0;
        drain();
        check_period = 1'b0;
        check("bp_accepts", ready_cnt, 3);
        check("bp_pulses", pulse_cnt, 3);

        // Abort in the SUM step of k=2, then a clean impulse response.
        do_reset();
        set_impulse_coefs();
        send(25'h0123456);
        drain();
        muestra_in = 25'h0ABCDEF;
        muestra_valid = 1'b1;
        cycle();
        muestra_valid = 1'b0;
        repeat (5) cycle();
        check("abort_in_sum", 32'(au_func), 32'd1);
        check("abort_addr", 32'(coef_addr), 32'd2);
        do_reset();
        pulse_cnt = 0;
        repeat (2 * TAPS + 4) cycle();
        check("abort_no_pulse", pulse_cnt, 0);
        send(25'h0010000);
        for (int i = 0; i < 3; i++) send('0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
